bmp280_measure_sequencer: RTL and testbench
===========================================

// Module: bmp280_measure_sequencer
// PURPOSE
// - Upstream master of spi_command_handler in the BMP280 driver. It owns the sensor
//   life cycle: soft-reset, ID check, config write, then periodic forced-mode
//   conversions.
// - Publishes raw 20-bit pressure/temperature words with a one-cycle valid strobe to
//   the compensation stage.
// - Talks only through the handler's cmd/addr/data/exec/busy/data_out interface.
// PARAMETERS
// - PACKAGE_SIZE    8          handler word width; must equal handler's PACKAGE_SIZE
// - BOOT_CYCLES     100000     wait after soft-reset before first access (2 ms @ 50 MHz)
// - PERIOD_CYCLES   5000000    trigger-to-trigger interval in periodic mode
// - TIMEOUT_CYCLES  65535      max cycles per handler transaction before error
// - POLL_MAX        255        max status reads per conversion before error
// - CTRL_MEAS_VAL   8'h25      ctrl_meas value: osrs_t=1, osrs_p=1, mode=forced
// - CONFIG_VAL      8'h00      config register value (t_sb, filter, spi3w_en=0)
// PORTS
// - clk           in   1    system clock
// - rstb          in   1    asynchronous, active-low reset
// - enable        in   1    1 = run init then periodic measurement; 0 = stop at next boundary
// - single        in   1    1 = one conversion per rising edge of 'start' instead of periodic
// - start         in   1    single-shot trigger (level sampled, edge-detected internally)
// - hc_cmd        out  PS   opcode to handler (CMD_WRITE_REG / CMD_READ_REG)
// - hc_addr       out  PS   8-bit BMP280 register address (handler strips bit 7)
// - hc_data       out  PS   write data to handler
// - hc_exec       out  1    one-cycle transaction request
// - hc_busy       in   1    handler busy
// - hc_data_out   in   PS   handler read data, valid when busy falls
// - raw_press     out  20   {F7,F8,F9[7:4]}
// - raw_temp      out  20   {FA,FB,FC[7:4]}
// - sample_valid  out  1    one-cycle strobe, raw_* updated on same edge
// - init_done     out  1    high after config write succeeded
// - error         out  1    sticky fault; cleared only by enable=0 or reset
// - err_code      out  2    0 none, 1 timeout, 2 bad ID (!=8'h58), 3 poll exhausted
// BEHAVIOUR
// - Reset: all outputs 0, raw_* 0, state IDLE, counters 0.
// - Transaction handshake (every register access):
//   - drive cmd/addr/data and pulse hc_exec for 1 cycle, only when hc_busy=0;
//   - wait for hc_busy=1 (ACK), then hc_busy=0 (DONE); capture hc_data_out on DONE;
//   - cmd/addr/data are held stable from exec until DONE;
//   - timeout counter runs from exec to DONE; reaching TIMEOUT_CYCLES -> ERROR, code 1.
// - States:
//   - IDLE -> RST_CHIP on enable=1.
//   - RST_CHIP: write 0xE0 <= 0xB6, then BOOT_WAIT.
//   - BOOT_WAIT: BOOT_CYCLES, then READ_ID.
//   - READ_ID: read 0xD0; value != 8'h58 -> ERROR (code 2), else WR_CFG.
//   - WR_CFG: write 0xF5 <= CONFIG_VAL; set init_done; then ARM.
//   - ARM: periodic: period counter hits PERIOD_CYCLES-1 -> TRIGGER (first trigger
//     immediate); single: start edge -> TRIGGER.
//   - TRIGGER: write 0xF4 <= CTRL_MEAS_VAL, then POLL.
//   - POLL: read 0xF3 until bit3 (measuring)=0 and bit0 (im_update)=0;
//     POLL_MAX reads -> ERROR (code 3).
//   - RD_DATA: 6 single reads 0xF7..0xFC into byte buffer, index 0..5.
//   - PUBLISH: load raw_*, pulse sample_valid, -> ARM.
//   - ERROR: hold error/err_code; never issue exec; enable=0 -> IDLE and clear.
// - Period counter runs in ARM/TRIGGER/POLL/RD_DATA/PUBLISH; it wraps at
//   PERIOD_CYCLES-1 and is not reset by a trigger. A conversion longer than the
//   period starts the next trigger immediately on return to ARM (no overlap, no
//   queueing of more than one).
// - enable=0 mid-transaction: complete the in-flight handshake, then IDLE;
//   no sample_valid; raw_* keep last values; init_done cleared.
// - start edges outside ARM are ignored; start while single=0 is ignored.
// - An unexpected hc_busy=1 while waiting to issue: exec is deferred, never dropped.
// STRUCTURE
// - Shared package/header (bmp280_regs.vh): register addresses (0xD0, 0xE0, 0xF3-0xFC),
//   RESET_WORD 8'hB6, CHIP_ID 8'h58, opcodes CMD_WRITE_REG/CMD_READ_REG shared with
//   handler, err_code values, state encodings.
// - Sub-module bmp280_xfer_port: exec/ACK/DONE handshake plus timeout; req/done/
//   timeout/rdata toward the sequencer FSM.
// TESTING (bench uses a behavioural handler + BMP280 register model)
// - Normal init: enable=1, ID 0x58 -> writes E0=B6, F5=00 seen in order; init_done=1
//   after BOOT_CYCLES.
// - Periodic sample: F7..FC = 65 5A C0 7E ED 00 -> raw_press=0x655AC,
//   raw_temp=0x7EED0, one sample_valid per PERIOD_CYCLES.
// - Poll: status=0x08 for 3 reads then 0x00 -> exactly 4 reads of F3 before F7;
//   status stuck 0x08 -> error=1, err_code=3 after POLL_MAX reads.
// - Bad ID 0x60 -> error=1, err_code=2, no further exec; enable=0 clears.
// - Handler never raises busy -> err_code=1 after TIMEOUT_CYCLES.
// - Single mode: two start pulses -> exactly two F4 writes and two sample_valid;
//   rstb low mid-RD_DATA -> all outputs 0 next edge, restart from RST_CHIP.

Source files
------------

// File: rtl/bmp280_measure_sequencer_pkg.sv
// Shared constants for the BMP280 measurement sequencer: register map, handler
// opcodes, error codes and state encodings.
package bmp280_measure_sequencer_pkg;

  localparam logic [7:0] REG_ID        = 8'hD0;
  localparam logic [7:0] REG_RESET     = 8'hE0;
  localparam logic [7:0] REG_STATUS    = 8'hF3;
  localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
  localparam logic [7:0] REG_CONFIG    = 8'hF5;
  localparam logic [7:0] REG_PRESS_MSB = 8'hF7;

  localparam logic [7:0] RESET_WORD    = 8'hB6;
  localparam logic [7:0] CHIP_ID       = 8'h58;

  localparam logic [7:0] CMD_WRITE_REG = 8'h01;
  localparam logic [7:0] CMD_READ_REG  = 8'h02;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_BAD_ID  = 2'd2,
    ERR_POLL    = 2'd3
  } err_code_t;

  typedef enum logic [3:0] {
    S_IDLE, S_RST_CHIP, S_BOOT_WAIT, S_READ_ID, S_WR_CFG, S_ARM,
    S_TRIGGER, S_POLL, S_RD_DATA, S_PUBLISH, S_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    X_IDLE, X_ISSUE, X_WAIT_ACK, X_WAIT_DONE
  } xfer_state_t;

  // Conversion finished: measuring (bit3) and im_update (bit0) both clear.
  function automatic logic status_ready(input logic [7:0] status);
    return !status[3] && !status[0];
  endfunction

endpackage

// File: rtl/bmp280_xfer_port.sv
// One handler transaction: latch request, exec when handler idle, wait ACK/DONE,
// return read data or flag a timeout.
module bmp280_xfer_port
  import bmp280_measure_sequencer_pkg::*;
#(
  parameter int unsigned PACKAGE_SIZE   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    req_i,
  input  logic [PACKAGE_SIZE-1:0] cmd_i,
  input  logic [PACKAGE_SIZE-1:0] addr_i,
  input  logic [PACKAGE_SIZE-1:0] wdata_i,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [PACKAGE_SIZE-1:0] rdata_o,
  output logic [PACKAGE_SIZE-1:0] hc_cmd_o,
  output logic [PACKAGE_SIZE-1:0] hc_addr_o,
  output logic [PACKAGE_SIZE-1:0] hc_data_o,
  output logic                    hc_exec_o,
  input  logic                    hc_busy_i,
  input  logic [PACKAGE_SIZE-1:0] hc_data_out_i
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  xfer_state_t             st_q;
  logic [PACKAGE_SIZE-1:0] cmd_q, addr_q, wdata_q, rdata_q;
  logic                    exec_q, done_q, tmo_q;
  logic [31:0]             tmr_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st_q    <= X_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exec_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      exec_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
      case (st_q)
        X_IDLE: if (req_i) begin
          cmd_q   <= cmd_i;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          st_q    <= X_ISSUE;
        end
        // A busy handler defers the exec rather than dropping it.
        X_ISSUE: if (!hc_busy_i) begin
          exec_q <= 1'b1;
          tmr_q  <= '0;
          st_q   <= X_WAIT_ACK;
        end
        default: begin
          if (st_q == X_WAIT_DONE && !hc_busy_i) begin
            done_q  <= 1'b1;
            rdata_q <= hc_data_out_i;
            st_q    <= X_IDLE;
          end else if (tmr_q == TMO_LAST) begin
            tmo_q <= 1'b1;
            st_q  <= X_IDLE;
          end else begin
            tmr_q <= tmr_q + 32'd1;
            if (hc_busy_i) st_q <= X_WAIT_DONE;
          end
        end
      endcase
    end
  end

  assign done_o    = done_q;
  assign timeout_o = tmo_q;
  assign rdata_o   = rdata_q;
  assign hc_cmd_o  = cmd_q;
  assign hc_addr_o = addr_q;
  assign hc_data_o = wdata_q;
  assign hc_exec_o = exec_q;

endmodule

// File: rtl/bmp280_measure_sequencer.sv
// BMP280 life-cycle master: soft-reset, ID check, config write, then forced-mode
// conversions (periodic or start-triggered) publishing raw pressure/temperature.
module bmp280_measure_sequencer
  import bmp280_measure_sequencer_pkg::*;
#(
  parameter int unsigned PACKAGE_SIZE   = 8,
  parameter int unsigned BOOT_CYCLES    = 100000,
  parameter int unsigned PERIOD_CYCLES  = 5000000,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned POLL_MAX       = 255,
  parameter logic [7:0]  CTRL_MEAS_VAL  = 8'h25,
  parameter logic [7:0]  CONFIG_VAL     = 8'h00
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    enable,
  input  logic                    single,
  input  logic                    start,
  output logic [PACKAGE_SIZE-1:0] hc_cmd,
  output logic [PACKAGE_SIZE-1:0] hc_addr,
  output logic [PACKAGE_SIZE-1:0] hc_data,
  output logic                    hc_exec,
  input  logic                    hc_busy,
  input  logic [PACKAGE_SIZE-1:0] hc_data_out,
  output logic [19:0]             raw_press,
  output logic [19:0]             raw_temp,
  output logic                    sample_valid,
  output logic                    init_done,
  output logic                    error,
  output logic [1:0]              err_code
);

  localparam int unsigned PS = PACKAGE_SIZE;

  seq_state_t  st_q;
  err_code_t   err_q;
  logic        pend_q, req_q, start_q, init_q, error_q, sv_q, trig_pend_q;
  logic [31:0] wait_q, pcnt_q, poll_q;
  logic [2:0]  idx_q;
  logic [7:0]  buf_q [6];
  logic [19:0] press_q, temp_q;

  logic          x_done, x_tmo, p_hit, run_state;
  logic [PS-1:0] x_rdata, tx_cmd, tx_addr, tx_wdata;
  logic [7:0]    rbyte;

  assign rbyte     = x_rdata[7:0];
  assign p_hit     = (pcnt_q == 32'(PERIOD_CYCLES - 1));
  assign run_state = st_q inside {S_ARM, S_TRIGGER, S_POLL, S_RD_DATA, S_PUBLISH};

  always_comb begin
    tx_cmd   = PS'(CMD_READ_REG);
    tx_addr  = '0;
    tx_wdata = '0;
    case (st_q)
      S_RST_CHIP: begin
        tx_cmd   = PS'(CMD_WRITE_REG);
        tx_addr  = PS'(REG_RESET);
        tx_wdata = PS'(RESET_WORD);
      end
      S_READ_ID:  tx_addr = PS'(REG_ID);
      S_WR_CFG: begin
        tx_cmd   = PS'(CMD_WRITE_REG);
        tx_addr  = PS'(REG_CONFIG);
        tx_wdata = PS'(CONFIG_VAL);
      end
      S_TRIGGER: begin
        tx_cmd   = PS'(CMD_WRITE_REG);
        tx_addr  = PS'(REG_CTRL_MEAS);
        tx_wdata = PS'(CTRL_MEAS_VAL);
      end
      S_POLL:     tx_addr = PS'(REG_STATUS);
      S_RD_DATA:  tx_addr = PS'(REG_PRESS_MSB + {5'd0, idx_q});
      default: ;
    endcase
  end

  bmp280_xfer_port #(
    .PACKAGE_SIZE   (PACKAGE_SIZE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_xfer (
    .clk           (clk),
    .rstb          (rstb),
    .req_i         (req_q),
    .cmd_i         (tx_cmd),
    .addr_i        (tx_addr),
    .wdata_i       (tx_wdata),
    .done_o        (x_done),
    .timeout_o     (x_tmo),
    .rdata_o       (x_rdata),
    .hc_cmd_o      (hc_cmd),
    .hc_addr_o     (hc_addr),
    .hc_data_o     (hc_data),
    .hc_exec_o     (hc_exec),
    .hc_busy_i     (hc_busy),
    .hc_data_out_i (hc_data_out)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st_q        <= S_IDLE;
      err_q       <= ERR_NONE;
      pend_q      <= 1'b0;
      req_q       <= 1'b0;
      start_q     <= 1'b0;
      init_q      <= 1'b0;
      error_q     <= 1'b0;
      sv_q        <= 1'b0;
      trig_pend_q <= 1'b0;
      wait_q      <= '0;
      pcnt_q      <= '0;
      poll_q      <= '0;
      idx_q       <= '0;
      press_q     <= '0;
      temp_q      <= '0;
      for (int unsigned i = 0; i < 6; i++) buf_q[i] <= '0;
    end else begin
      req_q   <= 1'b0;
      sv_q    <= 1'b0;
      start_q <= start;
      // Free-running period timer; a wrap seen outside ARM is remembered (one deep).
      if (run_state) begin
        pcnt_q <= p_hit ? '0 : pcnt_q + 32'd1;
        if (p_hit) trig_pend_q <= 1'b1;
      end
      case (st_q)
        S_IDLE: begin
          init_q  <= 1'b0;
          error_q <= 1'b0;
          err_q   <= ERR_NONE;
          pend_q  <= 1'b0;
          if (enable) st_q <= S_RST_CHIP;
        end
        S_BOOT_WAIT: begin
          if (!enable) st_q <= S_IDLE;
          else if (wait_q == 32'(BOOT_CYCLES - 1)) st_q <= S_READ_ID;
          else wait_q <= wait_q + 32'd1;
        end
        S_ARM: begin
          if (!enable) begin
            st_q <= S_IDLE;
          end else if (single) begin
            trig_pend_q <= 1'b0;
            if (start && !start_q) st_q <= S_TRIGGER;
          end else if (p_hit || trig_pend_q) begin
            trig_pend_q <= 1'b0;
            st_q        <= S_TRIGGER;
          end
        end
        S_PUBLISH: begin
          if (!enable) begin
            st_q <= S_IDLE;
          end else begin
            press_q <= {buf_q[0], buf_q[1], buf_q[2][7:4]};
            temp_q  <= {buf_q[3], buf_q[4], buf_q[5][7:4]};
            sv_q    <= 1'b1;
            st_q    <= S_ARM;
          end
        end
        S_ERROR: if (!enable) st_q <= S_IDLE;
        // Register-access states: issue once, then wait for the port's verdict.
        default: begin
          if (!pend_q) begin
            if (!enable) st_q <= S_IDLE;
            else begin
              req_q  <= 1'b1;
              pend_q <= 1'b1;
            end
          end else if (x_done || x_tmo) begin
            pend_q <= 1'b0;
            if (!enable) begin
              st_q <= S_IDLE;
            end else if (x_tmo) begin
              error_q <= 1'b1;
              err_q   <= ERR_TIMEOUT;
              st_q    <= S_ERROR;
            end else begin
              case (st_q)
                S_RST_CHIP: begin
                  wait_q <= '0;
                  st_q   <= S_BOOT_WAIT;
                end
                S_READ_ID: begin
                  if (rbyte != CHIP_ID) begin
                    error_q <= 1'b1;
                    err_q   <= ERR_BAD_ID;
                    st_q    <= S_ERROR;
                  end else st_q <= S_WR_CFG;
                end
                S_WR_CFG: begin
                  init_q      <= 1'b1;
                  pcnt_q      <= 32'(PERIOD_CYCLES - 1);
                  trig_pend_q <= 1'b0;
                  st_q        <= S_ARM;
                end
                S_TRIGGER: begin
                  poll_q <= '0;
                  st_q   <= S_POLL;
                end
                S_POLL: begin
                  if (status_ready(rbyte)) begin
                    idx_q <= '0;
                    st_q  <= S_RD_DATA;
                  end else if (poll_q == 32'(POLL_MAX - 1)) begin
                    error_q <= 1'b1;
                    err_q   <= ERR_POLL;
                    st_q    <= S_ERROR;
                  end else poll_q <= poll_q + 32'd1;
                end
                S_RD_DATA: begin
                  buf_q[idx_q] <= rbyte;
                  if (idx_q == 3'd5) st_q <= S_PUBLISH;
                  else idx_q <= idx_q + 3'd1;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign raw_press    = press_q;
  assign raw_temp     = temp_q;
  assign sample_valid = sv_q;
  assign init_done    = init_q;
  assign error        = error_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_bmp280_measure_sequencer.sv
// Scoreboard bench: behavioural handler + BMP280 register model; expected
// transactions and samples are queued by the stimulus and popped by monitors.
module tb_bmp280_measure_sequencer;
  import bmp280_measure_sequencer_pkg::*;

  localparam int unsigned BOOT = 20, PERIOD = 400, TMO = 40, PMAX = 6;

  logic        clk = 1'b0, rstb = 1'b0, enable = 1'b0, single = 1'b0, start = 1'b0;
  logic [7:0]  hc_cmd, hc_addr, hc_data;
  logic [7:0]  hc_data_out = 8'h00;
  logic        hc_exec, hc_busy = 1'b0;
  logic [19:0] raw_press, raw_temp;
  logic        sample_valid, init_done, error;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  bmp280_measure_sequencer #(
    .PACKAGE_SIZE(8), .BOOT_CYCLES(BOOT), .PERIOD_CYCLES(PERIOD),
    .TIMEOUT_CYCLES(TMO), .POLL_MAX(PMAX), .CTRL_MEAS_VAL(8'h25), .CONFIG_VAL(8'h00)
  ) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .single(single), .start(start),
    .hc_cmd(hc_cmd), .hc_addr(hc_addr), .hc_data(hc_data), .hc_exec(hc_exec),
    .hc_busy(hc_busy), .hc_data_out(hc_data_out), .raw_press(raw_press),
    .raw_temp(raw_temp), .sample_valid(sample_valid), .init_done(init_done),
    .error(error), .err_code(err_code)
  );

  int unsigned errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- handler + register model ----------------
  logic [7:0]  chip_id = 8'h58;
  int unsigned status_busy_reads = 3;
  bit          no_busy = 1'b0;
  bit          hb_act = 1'b0;
  int unsigned hb_cnt = 0, f3_seen = 0, f4_count = 0;
  logic [7:0]  hb_cmd = 8'h00, hb_addr = 8'h00;

  function automatic logic [7:0] reg_read(input logic [7:0] a, input int unsigned f3n);
    case (a)
      8'hD0: return chip_id;
      8'hF3: return (f3n < status_busy_reads) ? 8'h08 : 8'h00;
      8'hF7: return 8'h65;
      8'hF8: return 8'h5A;
      8'hF9: return 8'hC0;
      8'hFA: return 8'h7E;
      8'hFB: return 8'hED;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (hb_act) begin
      if (hb_cnt == 2) begin
        hc_busy <= 1'b0;
        hb_act  <= 1'b0;
        if (hb_cmd == CMD_READ_REG) begin
          hc_data_out <= reg_read(hb_addr, f3_seen);
          if (hb_addr == 8'hF3) f3_seen <= f3_seen + 1;
        end
      end else hb_cnt <= hb_cnt + 1;
    end else if (hc_exec && !no_busy) begin
      hb_act  <= 1'b1;
      hb_cnt  <= 0;
      hc_busy <= 1'b1;
      hb_cmd  <= hc_cmd;
      hb_addr <= hc_addr;
      if (hc_cmd == CMD_WRITE_REG && hc_addr == 8'hF4) begin
        f3_seen  <= 0;
        f4_count <= f4_count + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [7:0] cmd; logic [7:0] addr; logic [7:0] data; } tx_t;
  tx_t         exp_tx[$];
  logic [19:0] exp_press[$], exp_temp[$];
  bit          tx_check = 1'b1;
  int unsigned n_samples = 0, last_sv = 0;

  always @(negedge clk) begin
    if (rstb && hc_exec && tx_check) begin
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_exec: got cmd 0x%0h addr 0x%0h, none expected", hc_cmd, hc_addr);
      end else begin
        tx_t e;
        e = exp_tx.pop_front();
        chk("tx_cmd", 64'(hc_cmd), 64'(e.cmd));
        chk("tx_addr", 64'(hc_addr), 64'(e.addr));
        if (e.cmd == CMD_WRITE_REG) chk("tx_wdata", 64'(hc_data), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rstb && sample_valid) begin
      if (exp_press.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_sample: got press 0x%0h temp 0x%0h", raw_press, raw_temp);
      end else begin
        chk("raw_press", 64'(raw_press), 64'(exp_press.pop_front()));
        chk("raw_temp", 64'(raw_temp), 64'(exp_temp.pop_front()));
      end
      if (n_samples == 1) chk("sample_period", 64'(cyc - last_sv), 64'(PERIOD));
      last_sv = cyc;
      n_samples++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_tx(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data);
    tx_t t;
    t.cmd = cmd; t.addr = addr; t.data = data;
    exp_tx.push_back(t);
  endtask

  task automatic push_conv(input int unsigned n_f3);
    push_tx(CMD_WRITE_REG, 8'hF4, 8'h25);
    for (int unsigned i = 0; i < n_f3; i++) push_tx(CMD_READ_REG, 8'hF3, 8'h00);
    for (int unsigned a = 8'hF7; a <= 8'hFC; a++) push_tx(CMD_READ_REG, 8'(a), 8'h00);
    exp_press.push_back(20'h655AC);
    exp_temp.push_back(20'h7EED0);
  endtask

  int unsigned samp_target = 0;
  function automatic bit cond(input int unsigned which);
    case (which)
      0: return error;
      1: return init_done;
      2: return n_samples >= samp_target;
      3: return exp_tx.size() == 0;
      default: return hb_act && hb_addr == 8'hF9;
    endcase
  endfunction

  task automatic wait_cond(input int unsigned which, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (!cond(which) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (!cond(which)) begin
      checks++; errors++;
      $display("FAIL %s: condition not reached within %0d cycles", tag, budget);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic disable_and_check(input string tag);
    @(negedge clk) enable = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_cleared"}, 64'({init_done, error, err_code}), 64'(0));
  endtask

  initial begin
    int unsigned t0, f4_base, s_base;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", 64'({hc_exec, sample_valid, init_done, error, err_code}), 64'(0));
    chk("reset_raw", 64'({raw_press, raw_temp}), 64'(0));
    chk("reset_hc", 64'({hc_cmd, hc_addr, hc_data}), 64'(0));
    @(negedge clk) rstb = 1'b1;

    // Periodic: init order, two samples one period apart, 4 status polls each.
    push_tx(CMD_WRITE_REG, 8'hE0, 8'hB6);
    push_tx(CMD_READ_REG, 8'hD0, 8'h00);
    push_tx(CMD_WRITE_REG, 8'hF5, 8'h00);
    push_conv(4);
    push_conv(4);
    @(negedge clk) enable = 1'b1;
    t0 = cyc;
    wait_cond(1, 500, "init_done_wait");
    chk("init_after_boot", 64'((cyc - t0 >= BOOT) && (cyc - t0 < BOOT + 60)), 64'(1));
    samp_target = 2;
    wait_cond(2, 2000, "periodic_samples_wait");
    disable_and_check("periodic");
    chk("periodic_tx_consumed", 64'(exp_tx.size()), 64'(0));

    // Status stuck busy: error 3 after exactly POLL_MAX status reads.
    tx_check = 1'b0;
    status_busy_reads = 1000;
    @(negedge clk) enable = 1'b1;
    wait_cond(0, 3000, "poll_error_wait");
    chk("poll_err_code", 64'(err_code), 64'(ERR_POLL));
    chk("poll_read_count", 64'(f3_seen), 64'(PMAX));
    disable_and_check("poll");

    // Bad chip ID: error 2 and no further exec.
    status_busy_reads = 0;
    chip_id = 8'h60;
    tx_check = 1'b1;
    push_tx(CMD_WRITE_REG, 8'hE0, 8'hB6);
    push_tx(CMD_READ_REG, 8'hD0, 8'h00);
    @(negedge clk) enable = 1'b1;
    wait_cond(0, 500, "badid_error_wait");
    chk("badid_err_code", 64'(err_code), 64'(ERR_BAD_ID));
    repeat (50) @(negedge clk);
    chk("badid_tx_consumed", 64'(exp_tx.size()), 64'(0));
    disable_and_check("badid");
    chip_id = 8'h58;

    // Handler never acknowledges: timeout error.
    no_busy = 1'b1;
    push_tx(CMD_WRITE_REG, 8'hE0, 8'hB6);
    @(negedge clk) enable = 1'b1;
    wait_cond(0, 300, "timeout_error_wait");
    chk("timeout_err_code", 64'(err_code), 64'(ERR_TIMEOUT));
    disable_and_check("timeout");
    no_busy = 1'b0;

    // Single-shot: two start pulses -> two F4 writes, two samples.
    tx_check = 1'b0;
    single = 1'b1;
    f4_base = f4_count;
    s_base = n_samples;
    @(negedge clk) enable = 1'b1;
    wait_cond(1, 500, "single_init_wait");
    repeat (30) @(negedge clk);
    chk("single_no_autotrigger", 64'(f4_count - f4_base), 64'(0));
    exp_press.push_back(20'h655AC); exp_temp.push_back(20'h7EED0);
    exp_press.push_back(20'h655AC); exp_temp.push_back(20'h7EED0);
    pulse_start();
    samp_target = s_base + 1;
    wait_cond(2, 500, "single_sample1_wait");
    pulse_start();
    samp_target = s_base + 2;
    wait_cond(2, 500, "single_sample2_wait");
    repeat (20) @(negedge clk);
    chk("single_f4_writes", 64'(f4_count - f4_base), 64'(2));
    chk("single_samples", 64'(n_samples - s_base), 64'(2));

    // Reset in the middle of RD_DATA, then restart from RST_CHIP.
    pulse_start();
    wait_cond(4, 500, "rd_data_reach_wait");
    #1 rstb = 1'b0;
    #1;
    chk("midrun_reset_ctl", 64'({hc_exec, sample_valid, init_done, error, err_code}), 64'(0));
    chk("midrun_reset_raw", 64'({raw_press, raw_temp}), 64'(0));
    tx_check = 1'b1;
    push_tx(CMD_WRITE_REG, 8'hE0, 8'hB6);
    push_tx(CMD_READ_REG, 8'hD0, 8'h00);
    push_tx(CMD_WRITE_REG, 8'hF5, 8'h00);
    @(negedge clk) rstb = 1'b1;
    wait_cond(1, 500, "restart_init_wait");
    chk("restart_tx_consumed", 64'(exp_tx.size()), 64'(0));
    disable_and_check("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
